orb_seq_ctrl: RTL and testbench
===============================

ORB_SEQ_CTRL -- requirements
Module: orb_seq_ctrl

Interface
REQ-001 SHALL have parameter PARAM_WIDTH, default 8: number of parameter-SRAM words.
REQ-002 SHALL have parameter MAX_KERNEL, default 31: largest legal kernel size.
REQ-003 SHALL have parameter X_MAX, default 400: largest legal image width.
REQ-004 SHALL have parameter Y_MAX, default 400: largest legal image height.
REQ-005 SHALL have parameter PIXEL_DEPTH, default 8: parameter-SRAM data width.
REQ-006 Ports (all synchronous to clk):
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- addr_params  out  $clog2(PARAM_WIDTH)  parameter-SRAM read address.
- ren_params  out  1  parameter-SRAM read enable.
- rdat_params  in  PIXEL_DEPTH  read data, valid the cycle after ren_params.
- waddr_params  out  $clog2(PARAM_WIDTH)  parameter-SRAM write address.
- wen_params  out  1  parameter-SRAM write enable.
- wdat_params  out  PIXEL_DEPTH  write data.
- kernel_size  out  $clog2(MAX_KERNEL)+1  to the convolution stage.
- sigma  out  PIXEL_DEPTH  to the convolution stage.
- max_x  out  $clog2(X_MAX)+1  image width.
- max_y  out  $clog2(Y_MAX)+1  image height.
- new_trans  out  1  one-cycle convolution start pulse.
- conv_done  in  1  convolution-complete pulse.
- fast_start  out  1  one-cycle FAST-stage start pulse.
- fast_done  in  1  FAST-complete pulse.
- busy  out  1  high outside IDLE/POLL.
- err  out  1  sticky: last job rejected.

Function
REQ-007 Parameter map: NEW_IMG=0, X_LO=1, X_HI=2, Y_LO=3, Y_HI=4, KERNEL=5, SIGMA=6, DONE=7.
REQ-008 FSM states: IDLE, POLL, LOAD, CHECK, START_CONV, WAIT_CONV, START_FAST, WAIT_FAST, FINISH, ERROR.
REQ-009 IDLE: ren_params=1, addr_params=0; next state is POLL.
REQ-010 POLL: rdat_params != 0 -> LOAD; otherwise -> IDLE. Polling interval is 2 cycles.
REQ-011 LOAD: in the first LOAD cycle, write DONE<=0.
REQ-012 LOAD: issue reads of addresses 1..6 on consecutive cycles and capture each word one cycle later.
REQ-013 LOAD lasts 7 cycles, then goes to CHECK.
REQ-014 Width values are assembled as {X_HI,X_LO} and {Y_HI,Y_LO}, 16-bit, in internal registers.
REQ-015 CHECK fails if any of these holds:
- kernel==0, kernel even, or kernel>MAX_KERNEL;
- width==0 or width>X_MAX;
- height==0 or height>Y_MAX.
REQ-016 CHECK fail -> ERROR; pass -> START_CONV.
REQ-017 Comparisons SHALL use the full 16-bit or 8-bit values; truncate to output width only after a pass.
REQ-018 kernel_size, sigma, max_x and max_y SHALL update only on the CHECK->START_CONV transition.
REQ-019 Those outputs SHALL then hold stable until the next successful CHECK.
REQ-020 START_CONV: new_trans=1 for exactly one cycle, then WAIT_CONV.
REQ-021 WAIT_CONV: conv_done -> START_FAST. conv_done in any other state is ignored.
REQ-022 START_FAST: fast_start=1 for exactly one cycle, then WAIT_FAST.
REQ-023 WAIT_FAST: fast_done -> FINISH. fast_done in any other state is ignored.
REQ-024 FINISH, 2 cycles: write NEW_IMG<=0, then write DONE<=1; clear err; then IDLE.
REQ-025 ERROR, 2 cycles: write NEW_IMG<=0, then write DONE<=8'h02; set err; then IDLE.
REQ-026 At most one SRAM write per cycle, and no write outside LOAD, FINISH and ERROR.
REQ-027 Writes are single-cycle with wen_params=1; waddr_params and wdat_params are don't-care when wen_params=0.
REQ-028 The read and write ports are independent. A LOAD read concurrent with the DONE write is legal.
REQ-029 End-to-end latency, poll-hit to new_trans: 1 (POLL) + 7 (LOAD) + 1 (CHECK) = new_trans asserted 9 cycles after the POLL cycle.
REQ-030 new_trans and fast_start SHALL never be asserted in the same cycle.

Reset
REQ-031 rst is asynchronous and active-high and puts the FSM in IDLE.
REQ-032 On rst, every output is 0: ren_params, wen_params, addr/wdat, new_trans, fast_start, busy, err, and all config outputs.
REQ-033 rst mid-job SHALL abandon the job with no further SRAM writes.
REQ-034 After an abandoned job, NEW_IMG is left unchanged, so the job re-runs after reset.

Structure
REQ-035 Package orb_pkg SHALL hold the parameter-address constants, the FSM state enum and the DONE status codes (1 = OK, 2 = ERR).
REQ-036 No sub-module is required. A single FSM with a LOAD index counter is natural; an optional loader may be split out as orb_param_loader.

Verification
REQ-037 Nominal job: NEW_IMG=1, X=400 (0x90,0x01), Y=300, K=7, S=2.
- Response: kernel_size=7, max_x=400, max_y=300, sigma=2.
- new_trans fires 9 cycles after the POLL hit.
- conv_done then produces fast_start the next cycle; fast_done then writes NEW_IMG=0, DONE=1.
REQ-038 Bad kernel: K=8 -> no new_trans; DONE=2; err=1; config outputs unchanged.
REQ-039 Oversize width: X=401 (0x91,0x01) -> ERROR; DONE=2.
- Then a valid job follows: err clears and DONE=1.
REQ-040 Spurious pulses: conv_done in WAIT_FAST and fast_done in WAIT_CONV -> ignored; no state change.
REQ-041 Reset in WAIT_CONV -> all outputs 0 immediately; no writes.
- After rst falls, NEW_IMG is still 1, so the job restarts.
REQ-042 Idle poll: NEW_IMG=0 for 100 cycles -> busy=0, no writes, ren_params toggles the IDLE/POLL pattern.

Source files
------------

// File: rtl/orb_pkg.sv
// Shared constants for the ORB sequencer: parameter-SRAM word map, DONE status
// codes and the controller state encoding.
package orb_pkg;

  // Parameter-SRAM word addresses
  localparam int unsigned ADDR_NEW_IMG = 0;
  localparam int unsigned ADDR_X_LO    = 1;
  localparam int unsigned ADDR_X_HI    = 2;
  localparam int unsigned ADDR_Y_LO    = 3;
  localparam int unsigned ADDR_Y_HI    = 4;
  localparam int unsigned ADDR_KERNEL  = 5;
  localparam int unsigned ADDR_SIGMA   = 6;
  localparam int unsigned ADDR_DONE    = 7;

  // Values written to the DONE word
  localparam int unsigned DONE_BUSY = 0;
  localparam int unsigned DONE_OK   = 1;
  localparam int unsigned DONE_ERR  = 2;

  typedef enum logic [3:0] {
    StIdle,
    StPoll,
    StLoad,
    StCheck,
    StStartConv,
    StWaitConv,
    StStartFast,
    StWaitFast,
    StFinish,
    StError
  } state_e;

endpackage

// File: rtl/orb_seq_ctrl.sv
// ORB job sequencer: polls the parameter SRAM for a new image, loads and
// validates the job parameters, then runs the convolution and FAST stages
// in turn and reports completion status back into the SRAM.
module orb_seq_ctrl
  import orb_pkg::*;
#(
  parameter int unsigned PARAM_WIDTH = 8,
  parameter int unsigned MAX_KERNEL  = 31,
  parameter int unsigned X_MAX       = 400,
  parameter int unsigned Y_MAX       = 400,
  parameter int unsigned PIXEL_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [$clog2(PARAM_WIDTH)-1:0] addr_params,
  output logic                           ren_params,
  input  logic [PIXEL_DEPTH-1:0]         rdat_params,
  output logic [$clog2(PARAM_WIDTH)-1:0] waddr_params,
  output logic                           wen_params,
  output logic [PIXEL_DEPTH-1:0]         wdat_params,
  output logic [$clog2(MAX_KERNEL):0]    kernel_size,
  output logic [PIXEL_DEPTH-1:0]         sigma,
  output logic [$clog2(X_MAX):0]         max_x,
  output logic [$clog2(Y_MAX):0]         max_y,
  output logic                           new_trans,
  input  logic                           conv_done,
  output logic                           fast_start,
  input  logic                           fast_done,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned AW = $clog2(PARAM_WIDTH);
  localparam int unsigned KW = $clog2(MAX_KERNEL) + 1;
  localparam int unsigned XW = $clog2(X_MAX) + 1;
  localparam int unsigned YW = $clog2(Y_MAX) + 1;
  localparam int unsigned PW = PIXEL_DEPTH;
  localparam int unsigned DW = 2 * PIXEL_DEPTH;

  state_e        r_state;
  logic [2:0]    r_idx;
  logic [DW-1:0] r_x;
  logic [DW-1:0] r_y;
  logic [PW-1:0] r_kernel;
  logic [PW-1:0] r_sigma;

  logic [AW-1:0] r_addr;
  logic          r_ren;
  logic [AW-1:0] r_waddr;
  logic          r_wen;
  logic [PW-1:0] r_wdat;
  logic [KW-1:0] r_kernel_size;
  logic [PW-1:0] r_sigma_out;
  logic [XW-1:0] r_max_x;
  logic [YW-1:0] r_max_y;
  logic          r_new_trans;
  logic          r_fast_start;
  logic          r_busy;
  logic          r_err;

  logic w_bad_kernel;
  logic w_bad_x;
  logic w_bad_y;
  logic w_check_ok;

  // Validation runs on the full captured values; truncation happens only on a pass
  assign w_bad_kernel = (r_kernel == '0) || !r_kernel[0] || (r_kernel > PW'(MAX_KERNEL));
  assign w_bad_x      = (r_x == '0) || (r_x > DW'(X_MAX));
  assign w_bad_y      = (r_y == '0) || (r_y > DW'(Y_MAX));
  assign w_check_ok   = !(w_bad_kernel || w_bad_x || w_bad_y);

  // Controller FSM; every output is registered and set on the transition into its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_kernel      <= '0;
      r_sigma       <= '0;
      r_addr        <= '0;
      r_ren         <= 1'b0;
      r_waddr       <= '0;
      r_wen         <= 1'b0;
      r_wdat        <= '0;
      r_kernel_size <= '0;
      r_sigma_out   <= '0;
      r_max_x       <= '0;
      r_max_y       <= '0;
      r_new_trans   <= 1'b0;
      r_fast_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_wen        <= 1'b0;
      r_new_trans  <= 1'b0;
      r_fast_start <= 1'b0;
      case (r_state)
        StIdle: begin
          // Straight out of reset no read is in flight yet, so issue one first
          if (r_ren) begin
            r_ren   <= 1'b0;
            r_state <= StPoll;
          end else begin
            r_ren  <= 1'b1;
            r_addr <= AW'(ADDR_NEW_IMG);
          end
        end
        StPoll: begin
          r_ren <= 1'b1;
          if (rdat_params != '0) begin
            r_state <= StLoad;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_addr  <= AW'(ADDR_X_LO);
            r_wen   <= 1'b1;
            r_waddr <= AW'(ADDR_DONE);
            r_wdat  <= PW'(DONE_BUSY);
          end else begin
            r_state <= StIdle;
            r_addr  <= AW'(ADDR_NEW_IMG);
          end
        end
        StLoad: begin
          // r_idx is also the address of the word arriving on rdat_params this cycle
          r_idx <= r_idx + 3'd1;
          case (r_idx)
            3'(ADDR_X_LO):   r_x[PW-1:0]  <= rdat_params;
            3'(ADDR_X_HI):   r_x[DW-1:PW] <= rdat_params;
            3'(ADDR_Y_LO):   r_y[PW-1:0]  <= rdat_params;
            3'(ADDR_Y_HI):   r_y[DW-1:PW] <= rdat_params;
            3'(ADDR_KERNEL): r_kernel     <= rdat_params;
            3'(ADDR_SIGMA):  r_sigma      <= rdat_params;
            default: ;
          endcase
          if (r_idx < 3'd5) begin
            r_addr <= AW'(r_idx) + AW'(2);
          end else begin
            r_ren <= 1'b0;
          end
          if (r_idx == 3'd6) begin
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (w_check_ok) begin
            r_state       <= StStartConv;
            r_new_trans   <= 1'b1;
            r_kernel_size <= KW'(r_kernel);
            r_sigma_out   <= r_sigma;
            r_max_x       <= XW'(r_x);
            r_max_y       <= YW'(r_y);
          end else begin
            r_state <= StError;
            r_idx   <= '0;
            r_wen   <= 1'b1;
            r_waddr <= AW'(ADDR_NEW_IMG);
            r_wdat  <= '0;
          end
        end
        StStartConv: r_state <= StWaitConv;
        StWaitConv: begin
          if (conv_done) begin
            r_state      <= StStartFast;
            r_fast_start <= 1'b1;
          end
        end
        StStartFast: r_state <= StWaitFast;
        StWaitFast: begin
          if (fast_done) begin
            r_state <= StFinish;
            r_idx   <= '0;
            r_wen   <= 1'b1;
            r_waddr <= AW'(ADDR_NEW_IMG);
            r_wdat  <= '0;
          end
        end
        StFinish, StError: begin
          // Second write reports status; then return to polling
          if (r_idx == '0) begin
            r_idx   <= 3'd1;
            r_wen   <= 1'b1;
            r_waddr <= AW'(ADDR_DONE);
            r_wdat  <= (r_state == StFinish) ? PW'(DONE_OK) : PW'(DONE_ERR);
            r_err   <= (r_state == StError);
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_ren   <= 1'b1;
            r_addr  <= AW'(ADDR_NEW_IMG);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign addr_params  = r_addr;
  assign ren_params   = r_ren;
  assign waddr_params = r_waddr;
  assign wen_params   = r_wen;
  assign wdat_params  = r_wdat;
  assign kernel_size  = r_kernel_size;
  assign sigma        = r_sigma_out;
  assign max_x        = r_max_x;
  assign max_y        = r_max_y;
  assign new_trans    = r_new_trans;
  assign fast_start   = r_fast_start;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule

// File: tb/tb_orb_seq_ctrl.sv
// Directed bench for orb_seq_ctrl with a behavioural parameter SRAM.
module tb_orb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] addr_params, waddr_params;
  logic       ren_params, wen_params;
  logic [7:0] rdat_params, wdat_params, sigma;
  logic [5:0] kernel_size;
  logic [9:0] max_x, max_y;
  logic       new_trans, conv_done, fast_start, fast_done, busy, err;

  logic [7:0] mem [8];
  logic       h_we;
  logic [2:0] h_addr;
  logic [7:0] h_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_nt     = 0;
  int n_overlap = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  orb_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .addr_params  (addr_params),
    .ren_params   (ren_params),
    .rdat_params  (rdat_params),
    .waddr_params (waddr_params),
    .wen_params   (wen_params),
    .wdat_params  (wdat_params),
    .kernel_size  (kernel_size),
    .sigma        (sigma),
    .max_x        (max_x),
    .max_y        (max_y),
    .new_trans    (new_trans),
    .conv_done    (conv_done),
    .fast_start   (fast_start),
    .fast_done    (fast_done),
    .busy         (busy),
    .err          (err)
  );

  // SRAM model: registered read, DUT write has priority over host loading
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ren_params) rdat_params <= mem[addr_params];
    if (wen_params) begin
      mem[waddr_params] <= wdat_params;
      n_writes <= n_writes + 1;
    end else if (h_we) begin
      mem[h_addr] <= h_data;
    end
    if (new_trans) n_nt <= n_nt + 1;
    if (new_trans && fast_start) n_overlap <= n_overlap + 1;
  end

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    h_we = 1'b1; h_addr = a; h_data = d;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic set_job(input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] k, input logic [7:0] s);
    host_wr(3'd1, x[7:0]); host_wr(3'd2, x[15:8]);
    host_wr(3'd3, y[7:0]); host_wr(3'd4, y[15:8]);
    host_wr(3'd5, k);      host_wr(3'd6, s);
    host_wr(3'd0, 8'd1);
  endtask

  // First LOAD cycle is recognised by the DONE<=0 write
  task automatic wait_load(output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (wen_params && waddr_params == 3'd7 && wdat_params == 8'd0) begin ok = 1'b1; c = cyc; end
    end
  endtask

  task automatic wait_nt(output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (new_trans) begin ok = 1'b1; c = cyc; end
    end
  endtask

  task automatic pulse_conv();
    conv_done = 1'b1; @(negedge clk); conv_done = 1'b0;
  endtask

  task automatic pulse_fast();
    fast_done = 1'b1; @(negedge clk); fast_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; conv_done = 1'b0; fast_done = 1'b0; h_we = 1'b0;
    for (int i = 0; i < 8; i++) host_wr(3'(i), 8'd0);
    n_checks++;
    if ({ren_params, wen_params, new_trans, fast_start, busy, err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000000",
        {ren_params, wen_params, new_trans, fast_start, busy, err});
    end
    n_checks++;
    if ({addr_params, waddr_params, wdat_params} !== 14'b0) begin
      n_fail++; $display("FAIL reset_addr got %h want 0", {addr_params, waddr_params, wdat_params});
    end
    n_checks++;
    if ({kernel_size, sigma, max_x, max_y} !== 34'b0) begin
      n_fail++; $display("FAIL reset_cfg got %h want 0", {kernel_size, sigma, max_x, max_y});
    end
  endtask

  task automatic test_idle_poll();
    int w0, bad_busy, bad_tog, highs;
    logic prev;
    w0 = n_writes; bad_busy = 0; bad_tog = 0; highs = 0; prev = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bad_busy++;
      if (ren_params === prev) bad_tog++;
      if (ren_params) highs++;
      prev = ren_params;
    end
    n_checks++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy got %0d busy cycles want 0", bad_busy); end
    n_checks++;
    if (n_writes != w0) begin n_fail++; $display("FAIL idle_writes got %0d want 0", n_writes - w0); end
    n_checks++;
    if (bad_tog != 0 || highs != 50) begin
      n_fail++; $display("FAIL idle_ren_pattern got %0d stalls %0d highs want 0 stalls 50 highs", bad_tog, highs);
    end
  endtask

  task automatic test_nominal();
    int cl, cn; bit ok1, ok2;
    set_job(16'd400, 16'd300, 8'd7, 8'd2);
    wait_load(cl, ok1);
    wait_nt(cn, ok2);
    n_checks++;
    if (!(ok1 && ok2) || cn - cl != 8) begin
      n_fail++; $display("FAIL nom_latency got load_ok=%0d nt_ok=%0d delta=%0d want delta 8", ok1, ok2, cn - cl);
    end
    n_checks++;
    if (kernel_size !== 6'd7 || max_x !== 10'd400 || max_y !== 10'd300 || sigma !== 8'd2) begin
      n_fail++; $display("FAIL nom_cfg got k=%0d x=%0d y=%0d s=%0d want 7 400 300 2",
        kernel_size, max_x, max_y, sigma);
    end
    @(negedge clk);
    n_checks++;
    if (new_trans !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL nom_nt_width got nt=%b busy=%b want 0 1", new_trans, busy);
    end
    repeat (3) @(negedge clk);
    pulse_conv();
    n_checks++;
    if (fast_start !== 1'b1) begin n_fail++; $display("FAIL nom_fast_start got %b want 1", fast_start); end
    @(negedge clk);
    n_checks++;
    if (fast_start !== 1'b0) begin n_fail++; $display("FAIL nom_fast_width got %b want 0", fast_start); end
    pulse_fast();
    repeat (5) @(negedge clk);
    n_checks++;
    if (mem[0] !== 8'd0 || mem[7] !== 8'd1 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL nom_finish got new_img=%0d done=%0d err=%b busy=%b want 0 1 0 0",
        mem[0], mem[7], err, busy);
    end
  endtask

  task automatic test_spurious();
    int cn, bad; bit ok;
    set_job(16'd288, 16'd240, 8'd5, 8'd9);
    wait_nt(cn, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL spur_start got timeout want new_trans"); end
    @(negedge clk);
    pulse_fast();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fast_start || wen_params || !busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL spur_fast_in_wait_conv got %0d bad cycles want 0", bad); end
    pulse_conv();
    n_checks++;
    if (fast_start !== 1'b1) begin n_fail++; $display("FAIL spur_fast_start got %b want 1", fast_start); end
    @(negedge clk);
    pulse_conv();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fast_start || wen_params || !busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL spur_conv_in_wait_fast got %0d bad cycles want 0", bad); end
    pulse_fast();
    repeat (5) @(negedge clk);
    n_checks++;
    if (mem[7] !== 8'd1 || kernel_size !== 6'd5 || max_x !== 10'd288 || max_y !== 10'd240 ||
        sigma !== 8'd9) begin
      n_fail++; $display("FAIL spur_result got done=%0d k=%0d x=%0d y=%0d s=%0d want 1 5 288 240 9",
        mem[7], kernel_size, max_x, max_y, sigma);
    end
  endtask

  task automatic test_bad_kernel();
    int cl, nt0; bit ok;
    nt0 = n_nt;
    set_job(16'd400, 16'd300, 8'd8, 8'd2);
    wait_load(cl, ok);
    for (int i = 0; i < 40 && mem[7] !== 8'd2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || mem[7] !== 8'd2 || mem[0] !== 8'd0 || err !== 1'b1) begin
      n_fail++; $display("FAIL badk_status got load=%0d done=%0d new_img=%0d err=%b want 1 2 0 1",
        ok, mem[7], mem[0], err);
    end
    n_checks++;
    if (n_nt != nt0) begin n_fail++; $display("FAIL badk_no_trans got %0d pulses want 0", n_nt - nt0); end
    n_checks++;
    if (kernel_size !== 6'd5 || max_x !== 10'd288 || max_y !== 10'd240 || sigma !== 8'd9) begin
      n_fail++; $display("FAIL badk_cfg_hold got k=%0d x=%0d y=%0d s=%0d want 5 288 240 9",
        kernel_size, max_x, max_y, sigma);
    end
  endtask

  task automatic test_oversize_then_valid();
    int cl, cn; bit ok1, ok2;
    mem_reset_done();
    set_job(16'd401, 16'd300, 8'd7, 8'd2);
    wait_load(cl, ok1);
    for (int i = 0; i < 40 && mem[7] !== 8'd2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok1 || mem[7] !== 8'd2 || err !== 1'b1) begin
      n_fail++; $display("FAIL oversize got load=%0d done=%0d err=%b want 1 2 1", ok1, mem[7], err);
    end
    // Boundary-valid job: kernel at MAX_KERNEL, height at Y_MAX
    set_job(16'd320, 16'd400, 8'd31, 8'd5);
    wait_nt(cn, ok2);
    repeat (2) @(negedge clk);
    pulse_conv();
    repeat (2) @(negedge clk);
    pulse_fast();
    repeat (5) @(negedge clk);
    n_checks++;
    if (!ok2 || err !== 1'b0 || mem[7] !== 8'd1) begin
      n_fail++; $display("FAIL recover got nt=%0d err=%b done=%0d want 1 0 1", ok2, err, mem[7]);
    end
    n_checks++;
    if (kernel_size !== 6'd31 || max_x !== 10'd320 || max_y !== 10'd400 || sigma !== 8'd5) begin
      n_fail++; $display("FAIL recover_cfg got k=%0d x=%0d y=%0d s=%0d want 31 320 400 5",
        kernel_size, max_x, max_y, sigma);
    end
  endtask

  // Puts a non-2 value in DONE so the error wait below cannot be satisfied early
  task automatic mem_reset_done();
    host_wr(3'd7, 8'd0);
  endtask

  task automatic test_reset_mid();
    int cn, w0; bit ok;
    set_job(16'd400, 16'd300, 8'd7, 8'd2);
    wait_nt(cn, ok);
    repeat (2) @(negedge clk);
    w0 = n_writes;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ren_params, wen_params, new_trans, fast_start, busy, err, addr_params, wdat_params,
         kernel_size, sigma, max_x, max_y} !== 51'b0) begin
      n_fail++; $display("FAIL midrst_outputs got ren=%b wen=%b busy=%b k=%0d x=%0d want all 0",
        ren_params, wen_params, busy, kernel_size, max_x);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_writes != w0 || mem[0] !== 8'd1) begin
      n_fail++; $display("FAIL midrst_no_write got writes=%0d new_img=%0d want 0 1", n_writes - w0, mem[0]);
    end
    rst = 1'b0;
    wait_nt(cn, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrst_restart got timeout want new_trans"); end
    repeat (2) @(negedge clk);
    pulse_conv();
    repeat (2) @(negedge clk);
    pulse_fast();
    repeat (5) @(negedge clk);
    n_checks++;
    if (mem[0] !== 8'd0 || mem[7] !== 8'd1 || kernel_size !== 6'd7 || max_x !== 10'd400) begin
      n_fail++; $display("FAIL midrst_rerun got new_img=%0d done=%0d k=%0d x=%0d want 0 1 7 400",
        mem[0], mem[7], kernel_size, max_x);
    end
  endtask

  initial begin
    test_reset();
    test_idle_poll();
    test_nominal();
    test_spurious();
    test_bad_kernel();
    test_oversize_then_valid();
    test_reset_mid();
    n_checks++;
    if (n_overlap != 0) begin
      n_fail++; $display("FAIL pulse_overlap got %0d cycles want 0", n_overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
